lsu_mem_master: RTL and testbench

Multi-cycle load/store initiator that sits between the pipeline's MEM stage and the word-addressed data memory. It accepts one access at a time from the CPU and converts the op, address and store data into a word request with byte enables. It waits for the memory's acknowledge, then aligns and extends load data. It also detects misaligned accesses and acknowledge timeouts.

---
 rtl/lsu_mem_master.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and the word-addressed data memory.
// Builds a word request with byte enables, waits for ack or timeout, then aligns/extends load data.
module lsu_mem_master #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  alo_q;
    logic [15:0] cnt;

    logic        is_word;
    logic        is_half;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] load_val;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Decode the incoming op into request fields; only meaningful in IDLE with start=1.
    always_comb begin
        is_word    = (op == 3'b000) || (op == 3'b101);
        is_half    = (op == 3'b001) || (op == 3'b010) || (op == 3'b110);
        is_store   = (op == 3'b101) || (op == 3'b110) || (op == 3'b111);
        misaligned = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
        req_be     = 4'b1111;
        req_wdata  = 32'h0;
        case (op)
            3'b101: req_wdata = wdata;
            3'b110: begin
                req_be    = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{wdata[15:0]}};
            end
            3'b111: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the returned word using the latched offset.
    always_comb begin
        half_sel = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_sel = 8'(mem_rdata >> {alo_q, 3'b000});
        load_val = 32'h0;
        case (op_q)
            3'b000: load_val = mem_rdata;
            3'b001: load_val = {{16{half_sel[15]}}, half_sel};
            3'b010: load_val = {16'h0, half_sel};
            3'b011: load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100: load_val = {24'h0, byte_sel};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 3'b000;
            alo_q     <= 2'b00;
            cnt       <= 16'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= 32'h0;
            err       <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        alo_q <= addr[1:0];
                        busy  <= 1'b1;
                        if (misaligned) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 2'b01;
                            rdata <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= req_be;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                REQ: begin
                    // A late ack still wins over the timeout in the final cycle.
                    if (mem_ack || cnt == CNT_LAST) begin
                        state     <= RESP;
                        done      <= 1'b1;
                        err       <= mem_ack ? 2'b00 : 2'b10;
                        rdata     <= mem_ack ? load_val : 32'h0;
                        cnt       <= 16'h0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_be    <= 4'h0;
                        mem_wdata <= 32'h0;
                    end else begin
                        cnt <= cnt + 16'h1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    err   <= 2'b00;
                    rdata <= 32'h0;
                    cnt   <= 16'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master, built with ACK_TIMEOUT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int testCount = 0;
    int failCount = 0;

    lsu_mem_master #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one access for a single clock edge, leaving the DUT one negedge past acceptance.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
        start = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait 'delay' REQ cycles without ack, then ack with the given word.
    task automatic ackAfter(input int delay, input logic [31:0] rd, input string tag);
        for (int i = 0; i < delay; i++) begin
            checkOutput({tag, " req held"}, 32'(mem_req), 32'h1);
            @(negedge clk);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
    endtask

    task automatic checkDone(input string tag, input logic [31:0] expRdata, input logic [1:0] expErr);
        checkOutput({tag, " done"}, 32'(done), 32'h1);
        checkOutput({tag, " rdata"}, rdata, expRdata);
        checkOutput({tag, " err"}, 32'(err), 32'(expErr));
        checkOutput({tag, " req low"}, 32'(mem_req), 32'h0);
        @(negedge clk);
        checkOutput({tag, " done pulse"}, 32'(done), 32'h0);
    endtask

    task automatic doLoad(input logic [2:0] o, input logic [31:0] a, input logic [31:0] rd,
                          input logic [31:0] expRdata, input string tag);
        applyStimulus(o, a, 32'h0);
        checkOutput({tag, " addr"}, mem_addr, {a[31:2], 2'b00});
        checkOutput({tag, " be"}, 32'(mem_be), 32'hF);
        ackAfter(1, rd, tag);
        checkDone(tag, expRdata, 2'b00);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset req", 32'(mem_req), 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);
        checkOutput("reset addr", mem_addr, 32'h0);
        @(negedge clk);

        applyStimulus(3'b000, 32'h0000_1004, 32'h0);
        checkOutput("lw req", 32'(mem_req), 32'h1);
        checkOutput("lw busy", 32'(busy), 32'h1);
        checkOutput("lw addr", mem_addr, 32'h0000_1004);
        checkOutput("lw be", 32'(mem_be), 32'hF);
        checkOutput("lw we", 32'(mem_we), 32'h0);
        ackAfter(2, 32'hDEAD_BEEF, "lw");
        checkDone("lw", 32'hDEAD_BEEF, 2'b00);

        doLoad(3'b011, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, "lb");
        doLoad(3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080, "lbu");
        doLoad(3'b001, 32'h0000_1002, 32'h80FF_1234, 32'hFFFF_80FF, "lh");
        doLoad(3'b010, 32'h0000_1002, 32'h80FF_1234, 32'h0000_80FF, "lhu");
        doLoad(3'b011, 32'h0000_1001, 32'h80FF_1234, 32'h0000_0012, "lb lane1");
        doLoad(3'b001, 32'h0000_1000, 32'h80FF_9234, 32'hFFFF_9234, "lh low");

        applyStimulus(3'b111, 32'h0000_2001, 32'h0000_00AB);
        checkOutput("sb we", 32'(mem_we), 32'h1);
        checkOutput("sb be", 32'(mem_be), 32'h2);
        checkOutput("sb wdata", mem_wdata, 32'hABAB_ABAB);
        checkOutput("sb addr", mem_addr, 32'h0000_2000);
        ackAfter(0, 32'hFFFF_FFFF, "sb");
        checkDone("sb", 32'h0, 2'b00);

        applyStimulus(3'b110, 32'h0000_2002, 32'h0000_1234);
        checkOutput("sh be", 32'(mem_be), 32'hC);
        checkOutput("sh wdata", mem_wdata, 32'h1234_1234);
        ackAfter(1, 32'h0, "sh");
        checkDone("sh", 32'h0, 2'b00);

        applyStimulus(3'b101, 32'h0000_2008, 32'hCAFE_F00D);
        checkOutput("sw wdata", mem_wdata, 32'hCAFE_F00D);
        checkOutput("sw be", 32'(mem_be), 32'hF);
        ackAfter(0, 32'h0, "sw");
        checkDone("sw", 32'h0, 2'b00);

        applyStimulus(3'b000, 32'h0000_3002, 32'h0);
        checkDone("lw misaligned", 32'h0, 2'b01);
        applyStimulus(3'b110, 32'h0000_3001, 32'h0);
        checkDone("sh misaligned", 32'h0, 2'b01);
        applyStimulus(3'b011, 32'h0000_3003, 32'h0);
        checkOutput("lb odd req", 32'(mem_req), 32'h1);
        checkOutput("lb odd addr", mem_addr, 32'h0000_3000);
        ackAfter(0, 32'h7F00_0000, "lb odd");
        checkDone("lb odd", 32'h0000_007F, 2'b00);

        // Timeout: mem_req must stay high for exactly four cycles.
        applyStimulus(3'b000, 32'h0000_4000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("timeout req", 32'(mem_req), 32'h1);
            checkOutput("timeout no done", 32'(done), 32'h0);
            @(negedge clk);
        end
        checkDone("timeout", 32'h0, 2'b10);
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("late ack done", 32'(done), 32'h0);
        checkOutput("late ack busy", 32'(busy), 32'h0);
        checkOutput("late ack req", 32'(mem_req), 32'h0);

        applyStimulus(3'b000, 32'h0000_4004, 32'h0);
        ackAfter(3, 32'h5555_AAAA, "ack last cycle");
        checkDone("ack last cycle", 32'h5555_AAAA, 2'b00);

        applyStimulus(3'b000, 32'h0000_5000, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst mid req", 32'(mem_req), 32'h0);
        checkOutput("rst mid busy", 32'(busy), 32'h0);
        checkOutput("rst mid done", 32'(done), 32'h0);
        @(negedge clk);
        checkOutput("rst no done", 32'(done), 32'h0);

        // A start held through busy and the done cycle is taken only from the next IDLE cycle.
        applyStimulus(3'b000, 32'h0000_6000, 32'h0);
        start = 1'b1; op = 3'b111; addr = 32'h0000_7001; wdata = 32'h0000_00CD;
        checkOutput("busy start addr", mem_addr, 32'h0000_6000);
        checkOutput("busy start we", 32'(mem_we), 32'h0);
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("first-cycle ack done", 32'(done), 32'h1);
        checkOutput("first-cycle ack rdata", rdata, 32'h0BAD_F00D);
        @(negedge clk);
        checkOutput("b2b idle req", 32'(mem_req), 32'h0);
        checkOutput("b2b idle busy", 32'(busy), 32'h0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b accept req", 32'(mem_req), 32'h1);
        checkOutput("b2b accept be", 32'(mem_be), 32'h2);
        checkOutput("b2b accept wdata", mem_wdata, 32'hCDCD_CDCD);
        ackAfter(0, 32'h0, "b2b");
        checkDone("b2b", 32'h0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
